// File: rtl/vault_alarm_ctrl_if.sv
// ---------------------------------------------------------------------------
// vault_alarm_ctrl_if
// Signal bundle between the vault switch inputs and the alarm controller.
//   porta       : vault door open (1) / closed (0)
//   relogio     : business hours (1) / after hours (0)
//   interruptor : manager override, 1 forces the system armed
//   ack         : alarm acknowledge / clear (level)
//   sirene      : siren drive
//   armado      : system armed
//   memoria     : alarm-has-fired memory
//   estado      : state code (IDLE=0 ARMED=1 PRE_ALARM=2 ALARM=3 MEMORY=4)
//   contagem    : remaining cycles in PRE_ALARM / ALARM, else 0
// Modports: master drives the switch inputs and observes the outputs,
//           slave is the controller side.
// CNT_W must match the CNT_W of the controller bound to it.
// ---------------------------------------------------------------------------
interface vault_alarm_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             porta;
    logic             relogio;
    logic             interruptor;
    logic             ack;
    logic             sirene;
    logic             armado;
    logic             memoria;
    logic [2:0]       estado;
    logic [CNT_W-1:0] contagem;

    modport master (
        output porta, relogio, interruptor, ack,
        input  sirene, armado, memoria, estado, contagem
    );

    modport slave (
        input  porta, relogio, interruptor, ack,
        output sirene, armado, memoria, estado, contagem
    );
endinterface

// File: rtl/vault_alarm_ctrl.sv
// ---------------------------------------------------------------------------
// vault_alarm_ctrl
// Armed/disarmed state machine for the bank-vault alarm: entry grace period,
// bounded siren time and a latched alarm memory cleared by acknowledge.
//
// Ports:
//   clk_2  : board clock, all state changes on its rising edge
//   reset  : asynchronous, active-high, forces IDLE and clears all outputs
//   bus    : vault_alarm_ctrl_if.slave (porta, relogio, interruptor, ack in;
//            sirene, armado, memoria, estado, contagem out)
//
// Parameters:
//   GRACE_CYCLES : cycles the door may stay open while armed (1..2^CNT_W-1)
//   SIREN_CYCLES : cycles the siren sounds before alarm memory (1..2^CNT_W-1)
//   CNT_W        : down-counter / contagem width (must match the interface)
//   BLINK_LOG2   : blink half-period is 2^BLINK_LOG2 cycles
//
// Build option: define VAULT_ALARM_BLINK_EN to make the siren blink during
// ALARM (starting at 1 on entry); otherwise the siren is steady in ALARM.
//
// All outputs are registered from the next-state decode (Moore outputs).
// ---------------------------------------------------------------------------
module vault_alarm_ctrl #(
    parameter int GRACE_CYCLES = 3,
    parameter int SIREN_CYCLES = 8,
    parameter int CNT_W        = 8,
    parameter int BLINK_LOG2   = 1
) (
    input logic               clk_2,
    input logic               reset,
    vault_alarm_ctrl_if.slave bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARMED  = 3'd1;
    localparam logic [2:0] ST_PRE    = 3'd2;
    localparam logic [2:0] ST_ALARM  = 3'd3;
    localparam logic [2:0] ST_MEMORY = 3'd4;

    localparam logic [CNT_W-1:0] GRACE_LOAD = CNT_W'(GRACE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);

    // Elaboration-time guard on the configuration.
    if (GRACE_CYCLES < 1 || GRACE_CYCLES > (2 ** CNT_W) - 1 ||
        SIREN_CYCLES < 1 || SIREN_CYCLES > (2 ** CNT_W) - 1 ||
        BLINK_LOG2 < 0) begin : g_bad_params
        $error("vault_alarm_ctrl: illegal parameter combination");
    end

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sirene_q, sirene_d;
    logic             armado_q;
    logic             memoria_q;
    logic             arm;
    logic             clear_req;

    // Next-state and counter decode. The counter is zero outside PRE_ALARM
    // and ALARM, is loaded only on entry to them and never wraps below 0.
    always_comb begin
        arm       = ~bus.relogio | bus.interruptor;
        clear_req = bus.ack & ~bus.porta;
        state_d   = state_q;
        cnt_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (arm) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                // Intrusion wins over a simultaneous disarm.
                if (bus.porta) begin
                    state_d = ST_PRE;
                    cnt_d   = GRACE_LOAD;
                end else if (!arm) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (!bus.porta) begin
                    state_d = ST_ARMED;
                end else if (!arm) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_ALARM;
                    cnt_d   = SIREN_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ALARM: begin
                // relogio/interruptor alone never cancel a running alarm.
                if (clear_req) begin
                    state_d = arm ? ST_ARMED : ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_MEMORY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_MEMORY: begin
                if (clear_req) state_d = arm ? ST_ARMED : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef VAULT_ALARM_BLINK_EN
    // Cycles spent in the current ALARM visit; restarted on every entry so
    // the siren always begins a visit in its "on" half-period.
    logic [BLINK_LOG2:0] phase_q, phase_d;

    always_comb begin
        phase_d = '0;
        if (state_d == ST_ALARM && state_q == ST_ALARM) begin
            phase_d = phase_q + 1'b1;
        end
        sirene_d = (state_d == ST_ALARM) && !phase_d[BLINK_LOG2];
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) phase_q <= '0;
        else       phase_q <= phase_d;
    end
`else
    always_comb begin
        sirene_d = (state_d == ST_ALARM);
    end
`endif

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sirene_q  <= 1'b0;
            armado_q  <= 1'b0;
            memoria_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sirene_q  <= sirene_d;
            armado_q  <= (state_d != ST_IDLE);
            memoria_q <= (state_d == ST_ALARM) || (state_d == ST_MEMORY);
        end
    end

    assign bus.estado   = state_q;
    assign bus.contagem = cnt_q;
    assign bus.sirene   = sirene_q;
    assign bus.armado   = armado_q;
    assign bus.memoria  = memoria_q;

endmodule

// File: tb/tb_vault_alarm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vault_alarm_ctrl
// Self-checking bench for vault_alarm_ctrl: a directed vector table, a few
// hand-written multi-cycle sequences (async reset, siren duration/blink) and
// a randomized run against a behavioural model built from timers and flags.
// ---------------------------------------------------------------------------
module tb_vault_alarm_ctrl;

    localparam int GRACE = 3;
    localparam int SIREN = 8;
    localparam int CW    = 8;
    localparam int BL2   = 1;

    logic clk_2 = 1'b0;
    logic reset = 1'b1;

    always #5 clk_2 = ~clk_2;

    vault_alarm_ctrl_if #(.CNT_W(CW)) bus ();

    vault_alarm_ctrl #(
        .GRACE_CYCLES (GRACE),
        .SIREN_CYCLES (SIREN),
        .CNT_W        (CW),
        .BLINK_LOG2   (BL2)
    ) dut (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input int est, input int sir,
                             input int arm, input int mem, input int cnt,
                             input bit chk_sir);
        check({tag, ".estado"},   int'(bus.estado),   est);
        if (chk_sir) check({tag, ".sirene"}, int'(bus.sirene), sir);
        check({tag, ".armado"},   int'(bus.armado),   arm);
        check({tag, ".memoria"},  int'(bus.memoria),  mem);
        check({tag, ".contagem"}, int'(bus.contagem), cnt);
    endtask

    task automatic drive(input bit p, input bit r, input bit i, input bit a);
        bus.porta       = p;
        bus.relogio     = r;
        bus.interruptor = i;
        bus.ack         = a;
    endtask

    // One clock: inputs applied on the falling edge, outputs read 1 ns after
    // the rising edge.
    task automatic cycle(input bit p, input bit r, input bit i, input bit a);
        @(negedge clk_2);
        drive(p, r, i, a);
        @(posedge clk_2);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    // armed: system armed; grace_left / siren_left: remaining cycles of the
    // respective timer, -1 when not running; latched: alarm has fired and is
    // not yet acknowledged; blink_age: cycles since the siren started.
    bit m_armed, m_latched;
    int m_grace, m_siren, m_blink;

    task automatic model_reset();
        m_armed = 0; m_latched = 0; m_grace = -1; m_siren = -1; m_blink = 0;
    endtask

    task automatic model_step(input bit p, input bit r, input bit i, input bit a);
        bit arm_c;
        arm_c = !r || i;
        if (m_latched) begin
            if (a && !p) begin
                m_siren = -1; m_latched = 0; m_armed = arm_c;
            end else if (m_siren == 0) begin
                m_siren = -1;
            end else if (m_siren > 0) begin
                m_siren--; m_blink++;
            end
        end else if (m_grace >= 0) begin
            if (!p) begin
                m_grace = -1;
            end else if (!arm_c) begin
                m_grace = -1; m_armed = 0;
            end else if (m_grace == 0) begin
                m_grace = -1; m_siren = SIREN - 1; m_latched = 1; m_blink = 0;
            end else begin
                m_grace--;
            end
        end else if (m_armed) begin
            if (p) m_grace = GRACE - 1;
            else if (!arm_c) m_armed = 0;
        end else if (arm_c) begin
            m_armed = 1;
        end
    endtask

    task automatic model_compare(input string tag);
        int est, sir, cnt;
        if (!m_armed)        est = 0;
        else if (m_siren >= 0) est = 3;
        else if (m_latched)  est = 4;
        else if (m_grace >= 0) est = 2;
        else                 est = 1;
        sir = (m_siren >= 0) ? 1 : 0;
`ifdef VAULT_ALARM_BLINK_EN
        if (m_siren >= 0 && ((m_blink >> BL2) & 1) == 1) sir = 0;
`endif
        cnt = (m_grace >= 0) ? m_grace : ((m_siren >= 0) ? m_siren : 0);
        check_out(tag, est, sir, int'(m_armed), int'(m_latched), cnt, 1'b1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit p, r, i, a;
        int est, sir, arm, mem, cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(input bit p, input bit r, input bit i, input bit a,
                              input int est, input int sir, input int arm,
                              input int mem, input int cnt);
        vec_t e;
        e.p = p; e.r = r; e.i = i; e.a = a;
        e.est = est; e.sir = sir; e.arm = arm; e.mem = mem; e.cnt = cnt;
        tbl.push_back(e);
    endfunction

    initial begin
        bit chk_sir;
        bit pp, rr, ii, aa;

        // Business hours: door activity is ignored.
        for (int k = 0; k < 10; k++) v(bit'(k % 2), 1, 0, 0, 0, 0, 0, 0, 0);
        // After hours, door held open: grace 2,1,0 then siren 7..0, memory.
        v(1, 0, 0, 0, 1, 0, 1, 0, 0);
        for (int c = GRACE - 1; c >= 0; c--) v(1, 0, 0, 0, 2, 0, 1, 0, c);
        for (int c = SIREN - 1; c >= 0; c--) v(1, 0, 0, 0, 3, 1, 1, 1, c);
        v(1, 0, 0, 0, 4, 0, 1, 1, 0);
        v(1, 0, 0, 0, 4, 0, 1, 1, 0);
        v(1, 0, 0, 1, 4, 0, 1, 1, 0);          // ack with door open ignored
        v(0, 0, 0, 1, 1, 0, 1, 0, 0);          // ack, door closed, armed
        // Short door pulse: back to ARMED, no siren.
        v(0, 0, 0, 0, 1, 0, 1, 0, 0);
        v(1, 0, 0, 0, 2, 0, 1, 0, 2);
        v(1, 0, 0, 0, 2, 0, 1, 0, 1);
        v(0, 0, 0, 0, 1, 0, 1, 0, 0);
        v(0, 0, 0, 0, 1, 0, 1, 0, 0);
        // ALARM: ack with door open does not clear, then clears to ARMED.
        for (int c = GRACE - 1; c >= 0; c--) v(1, 0, 0, 0, 2, 0, 1, 0, c);
        v(1, 0, 0, 0, 3, 1, 1, 1, 7);
        v(1, 0, 0, 1, 3, 1, 1, 1, 6);
        v(0, 0, 0, 1, 1, 0, 1, 0, 0);
        // Intrusion priority over disarm, then disarm from PRE_ALARM.
        v(1, 1, 0, 0, 2, 0, 1, 0, 2);
        v(1, 1, 0, 0, 0, 0, 0, 0, 0);
        // Hours begin during ALARM: no cancel; ack while disarmed -> IDLE.
        v(0, 0, 0, 0, 1, 0, 1, 0, 0);
        for (int c = GRACE - 1; c >= 0; c--) v(1, 0, 0, 0, 2, 0, 1, 0, c);
        v(1, 0, 0, 0, 3, 1, 1, 1, 7);
        v(1, 1, 0, 0, 3, 1, 1, 1, 6);
        v(0, 1, 0, 1, 0, 0, 0, 0, 0);
        // Manager override arms during business hours; ARMED disarm.
        v(0, 1, 1, 0, 1, 0, 1, 0, 0);
        v(0, 1, 0, 0, 0, 0, 0, 0, 0);

        // ---- reset ----
        drive(0, 1, 0, 0);
        reset = 1'b1;
        #12;
        check_out("reset", 0, 0, 0, 0, 0, 1'b1);
        @(negedge clk_2);
        reset = 1'b0;

        foreach (tbl[n]) begin
            chk_sir = 1'b1;
`ifdef VAULT_ALARM_BLINK_EN
            if (tbl[n].est == 3) chk_sir = 1'b0;
`endif
            cycle(tbl[n].p, tbl[n].r, tbl[n].i, tbl[n].a);
            check_out($sformatf("vec%0d", n), tbl[n].est, tbl[n].sir,
                      tbl[n].arm, tbl[n].mem, tbl[n].cnt, chk_sir);
        end

        // ---- siren duration (and blink pattern) then async reset ----
        cycle(0, 0, 0, 0);                       // IDLE -> ARMED
        for (int k = 0; k < GRACE + 1; k++) cycle(1, 0, 0, 0);
        for (int k = 0; k < SIREN; k++) begin
`ifdef VAULT_ALARM_BLINK_EN
            check($sformatf("siren_pat%0d", k), int'(bus.sirene),
                  (((k >> BL2) & 1) == 0) ? 1 : 0);
`else
            check($sformatf("siren_pat%0d", k), int'(bus.sirene), 1);
`endif
            check($sformatf("siren_est%0d", k), int'(bus.estado), 3);
            cycle(1, 0, 0, 0);
        end
        check("siren_end", int'(bus.sirene), 0);
        check("siren_mem", int'(bus.estado), 4);

        cycle(0, 0, 0, 1);                       // clear -> ARMED
        for (int k = 0; k < GRACE + 3; k++) cycle(1, 0, 0, 0);
        check("pre_rst_est", int'(bus.estado), 3);
        #2;
        reset = 1'b1;                            // between edges
        #1;
        check_out("async_rst", 0, 0, 0, 0, 0, 1'b1);
        @(negedge clk_2);
        drive(0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clk_2);
        #1;
        check_out("rst_release_arm", 1, 0, 1, 0, 0, 1'b1);
        cycle(0, 0, 0, 0);
        check_out("no_pending_mem", 1, 0, 1, 0, 0, 1'b1);

        // ---- randomized run against the model ----
        reset = 1'b1;
        #3;
        model_reset();
        @(negedge clk_2);
        reset = 1'b0;
        pp = 0; rr = 0; ii = 0; aa = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk_2);
            reset = 1'b0;
            if ($urandom_range(0, 7) == 0)  pp = ~pp;
            if ($urandom_range(0, 11) == 0) rr = ~rr;
            ii = ($urandom_range(0, 15) == 0);
            aa = ($urandom_range(0, 5) == 0);
            drive(pp, rr, ii, aa);
            @(posedge clk_2);
            model_step(pp, rr, ii, aa);
            #1;
            model_compare($sformatf("rnd%0d", k));
            if ($urandom_range(0, 249) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                model_reset();
                model_compare($sformatf("rnd_rst%0d", k));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
